// File: rtl/ti_pipe_in_buffer.sv
// Pipe-in ingress FIFO: captures host words into a RAM queue and reports free space to the host.
// Latency: a word written into an empty buffer appears on out_valid two edges later (no bypass).
// Backpressure: out_ready low freezes the output register; writes to a full RAM are dropped and flagged.
module ti_pipe_in_buffer #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  ti_clk,
  input  logic                  ti_soft_rst,
  input  logic                  ti_in_data_en,
  input  logic [15:0]           ti_in_data,
  output logic [15:0]           ti_in_available,
  output logic                  ti_overflow,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  out_valid,
  output logic [15:0]           out_data,
  input  logic                  out_ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  // Free-space reset value; a 65536-word RAM cannot be expressed in 16 bits, so it saturates.
  localparam logic [15:0] AVAIL_RST = (ADDR_WIDTH >= 16) ? 16'hFFFF : 16'(DEPTH);

  logic [15:0]         mem [DEPTH];

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] fill_count_q, fill_count_d;
  logic                out_valid_q, out_valid_d;
  logic [15:0]         out_data_q, out_data_d;
  logic                ti_overflow_q, ti_overflow_d;
  logic [15:0]         ti_in_available_q, ti_in_available_d;

  logic                full, empty, wr_acc, ld_en, ram_rd;
  logic [16:0]         free_words;

  // Next-state logic: accept writes, refill the output register, track occupancy and free space.
  always_comb begin
    full              = (fill_count_q == DEPTH_C);
    empty             = (fill_count_q == '0);
    wr_acc            = ti_in_data_en && !full;
    ld_en             = !out_valid_q || out_ready;
    ram_rd            = ld_en && !empty;

    wr_ptr_d          = wr_ptr_q;
    rd_ptr_d          = rd_ptr_q;
    fill_count_d      = fill_count_q;
    out_valid_d       = out_valid_q;
    out_data_d        = out_data_q;
    ti_overflow_d     = ti_overflow_q;
    ti_in_available_d = ti_in_available_q;
    free_words        = '0;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ONE_C;
    end

    // Fullness uses the current count, so a same-edge read never makes room for a same-edge write.
    if (ti_in_data_en && full) begin
      ti_overflow_d = 1'b1;
    end

    if (ram_rd) begin
      rd_ptr_d    = rd_ptr_q + ONE_C;
      out_data_d  = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
      out_valid_d = 1'b1;
    end else if (ld_en) begin
      out_valid_d = 1'b0;
    end

    if (wr_acc && !ram_rd) begin
      fill_count_d = fill_count_q + ONE_C;
    end else if (!wr_acc && ram_rd) begin
      fill_count_d = fill_count_q - ONE_C;
    end

    // Loaded from the next count so the registered value always matches fill_count.
    free_words        = 17'(DEPTH_C) - 17'(fill_count_d);
    ti_in_available_d = free_words[16] ? 16'hFFFF : free_words[15:0];
  end

  // RAM write port; contents are not reset because stale words are never read past rd_ptr.
  always_ff @(posedge ti_clk) begin
    if (wr_acc && !ti_soft_rst) begin
      mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= ti_in_data;
    end
  end

  // State registers with synchronous reset that discards everything buffered, output register included.
  always_ff @(posedge ti_clk) begin
    if (ti_soft_rst) begin
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      fill_count_q      <= '0;
      out_valid_q       <= 1'b0;
      out_data_q        <= 16'h0000;
      ti_overflow_q     <= 1'b0;
      ti_in_available_q <= AVAIL_RST;
    end else begin
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      fill_count_q      <= fill_count_d;
      out_valid_q       <= out_valid_d;
      out_data_q        <= out_data_d;
      ti_overflow_q     <= ti_overflow_d;
      ti_in_available_q <= ti_in_available_d;
    end
  end

  assign fill_count      = fill_count_q;
  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign ti_overflow     = ti_overflow_q;
  assign ti_in_available = ti_in_available_q;

endmodule
